fb_port_arbiter: RTL and testbench

- Shares one single-port 12-bit frame-buffer RAM between two requesters: the VGA pixel-fetch read path and the camera-capture write path.
- VGA reads cannot stall, so they always have strict priority.
- Capture writes are buffered in a small FIFO and drained on any cycle with no read.
- Sits between the capture block, the VGA master and the frame-buffer BRAM.

---
 rtl/fb_arb_pkg.sv | 19 +
 rtl/fb_wr_fifo.sv | 57 +++++
 rtl/fb_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared defaults and types for the frame-buffer port arbiter and its write FIFO.
package fb_arb_pkg;

    localparam int FB_ADDR_W     = 17;
    localparam int FB_DATA_W     = 12;
    localparam int FB_PIXELS_DEF = 76800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } grant_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of buffered capture writes; push is ignored when full, pop when empty.
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  wr_entry_t              i_entry,
    input  logic                   i_pop,
    output wr_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

    wr_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads have strict priority, capture writes drain from a FIFO.
// Optional saturating drop counter enabled by FB_PORT_ARBITER_DROP_CNT_EN.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FB_PIXELS  = FB_PIXELS_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic                        vga_clk25,
    input  logic                        vga_rst,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    input  logic                        wr_req,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        ovf,
    output logic                        addr_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(FB_PIXELS);

    grant_state_e      r_state;
    grant_state_e      w_next;
    logic [ADDR_W-1:0] r_slot_addr;
    logic [DATA_W-1:0] r_slot_data;
    logic              r_slot_oob;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [MEM_LAT:0]  r_vpipe;
    logic [MEM_LAT:0]  r_zpipe;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ovf;
    logic              r_addr_err;
    logic              w_rd_oob;
    logic              w_wr_oob;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_drop;
    wr_entry_t         w_entry;
    wr_entry_t         w_head;

    assign w_rd_oob   = (rd_addr >= ADDR_LIMIT);
    assign w_wr_oob   = (wr_addr >= ADDR_LIMIT);
    // Full is sampled before this cycle's pop, so a full FIFO drops even while draining.
    assign w_push     = wr_req && !w_wr_oob && !w_full;
    assign w_ovf_drop = wr_req && !w_wr_oob && w_full;
    assign w_pop      = (w_next == WR);
    assign w_entry    = '{addr: wr_addr, data: wr_data};

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (vga_clk25),
        .i_rst   (vga_rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge vga_clk25) begin
        if (vga_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = IDLE;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        if (rd_req) begin
            w_next = RD;
        end else if (!w_empty) begin
            w_next = WR;
        end
        case (r_state)
            RD: begin
                if (!r_slot_oob) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = r_slot_addr;
                end
            end
            WR: begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_slot_addr;
                w_mem_wdata = r_slot_data;
            end
            default: ;
        endcase
    end

    // The slot registers hold the granted request for one cycle before it reaches the RAM pins.
    always_ff @(posedge vga_clk25) begin
        if (vga_rst) begin
            r_slot_addr <= '0;
            r_slot_data <= '0;
            r_slot_oob  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_vpipe     <= '0;
            r_zpipe     <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_ovf       <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_slot_addr <= (w_next == RD) ? rd_addr : w_head.addr;
            r_slot_data <= w_head.data;
            r_slot_oob  <= (w_next == RD) && w_rd_oob;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_vpipe     <= {r_vpipe[MEM_LAT-1:0], (r_state == RD)};
            r_zpipe     <= {r_zpipe[MEM_LAT-1:0], r_slot_oob};
            r_rd_valid  <= r_vpipe[MEM_LAT];
            if (r_vpipe[MEM_LAT]) begin
                r_rd_data <= r_zpipe[MEM_LAT] ? '0 : mem_rdata;
            end
            if (w_ovf_drop) r_ovf <= 1'b1;
            if ((rd_req && w_rd_oob) || (wr_req && w_wr_oob)) r_addr_err <= 1'b1;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign ovf       = r_ovf;
    assign addr_err  = r_addr_err;
    assign wr_ready  = !w_full;

`ifdef FB_PORT_ARBITER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge vga_clk25) begin
        if (vga_rst) begin
            r_drop_cnt <= '0;
        end else if ((w_ovf_drop || (wr_req && w_wr_oob)) && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: queue-based reference model plus a RAM model.
module tb_fb_port_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int PIX   = 76800;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          vga_rst = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          ovf;
    logic          addr_err;
    logic [2:0]    fifo_level;
    logic [15:0]   drop_cnt;

    ev_t              exp_rd[$];
    ev_t              exp_mr[$];
    ev_t              exp_mw[$];
    logic [AW+DW-1:0] pend_q[$];
    logic             m_ovf = 1'b0;
    logic             m_aerr = 1'b0;
    int               m_drops = 0;
    int               checks = 0;
    int               failures = 0;
    int unsigned      cyc = 0;
    ev_t              mon_e;

    logic [DW-1:0] ram    [0:(1<<AW)-1];
    logic          ram_wr [0:(1<<AW)-1];

    always #20 clk = ~clk;

    fb_port_arbiter dut (
        .vga_clk25  (clk),
        .vga_rst    (vga_rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ovf        (ovf),
        .addr_err   (addr_err),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    // Background frame contents for addresses never written by the bench.
    function automatic logic [DW-1:0] gold(input logic [AW-1:0] a);
        if (a == 17'd16) return 12'hABC;
        return DW'((a * 149) + 7);
    endfunction

    // One-cycle-latency single-port RAM.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= (ram_wr[mem_addr] === 1'b1) ? ram[mem_addr] : gold(mem_addr);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d actual=present required=absent", name, cyc);
    endtask

    // Drive one cycle of inputs and advance the reference model for the edge that samples them.
    task automatic step(input logic rst, input logic r, input logic [AW-1:0] ra,
                        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int               sz;
        logic [31:0]      lbl;
        logic [AW+DW-1:0] p;
        @(negedge clk);
        #1;
        vga_rst = rst;
        rd_req  = r;
        rd_addr = ra;
        wr_req  = w;
        wr_addr = wa;
        wr_data = wd;
        lbl = cyc + 1;
        if (rst) begin
            exp_rd.delete();
            exp_mr.delete();
            exp_mw.delete();
            pend_q.delete();
            m_ovf   = 1'b0;
            m_aerr  = 1'b0;
            m_drops = 0;
        end else begin
            sz = pend_q.size();
            if (r) begin
                if (ra < PIX) begin
                    exp_mr.push_back('{cyc: lbl + 1, addr: ra, data: '0});
                    exp_rd.push_back('{cyc: lbl + 3, addr: ra, data: gold(ra)});
                end else begin
                    exp_rd.push_back('{cyc: lbl + 3, addr: ra, data: '0});
                    m_aerr = 1'b1;
                end
            end else if (sz > 0) begin
                p = pend_q.pop_front();
                exp_mw.push_back('{cyc: lbl + 1, addr: p[AW+DW-1:DW], data: p[DW-1:0]});
            end
            if (w) begin
                if (wa >= PIX) begin
                    m_aerr = 1'b1;
                    m_drops++;
                end else if (sz >= DEPTH) begin
                    m_ovf = 1'b1;
                    m_drops++;
                end else begin
                    pend_q.push_back({wa, wd});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: compares every DUT output event against the expected queues.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    unexpected("rd_valid_unexpected");
                end else begin
                    mon_e = exp_rd.pop_front();
                    chk("rd_valid_cycle", cyc, mon_e.cyc);
                    chk("rd_data", 32'(rd_data), 32'(mon_e.data));
                end
            end
            if (mem_en === 1'b1 && mem_we === 1'b1) begin
                if (exp_mw.size() == 0) begin
                    unexpected("mem_write_unexpected");
                end else begin
                    mon_e = exp_mw.pop_front();
                    chk("mem_write_cycle", cyc, mon_e.cyc);
                    chk("mem_write_addr", 32'(mem_addr), 32'(mon_e.addr));
                    chk("mem_write_data", 32'(mem_wdata), 32'(mon_e.data));
                end
            end else if (mem_en === 1'b1) begin
                if (exp_mr.size() == 0) begin
                    unexpected("mem_read_unexpected");
                end else begin
                    mon_e = exp_mr.pop_front();
                    chk("mem_read_cycle", cyc, mon_e.cyc);
                    chk("mem_read_addr", 32'(mem_addr), 32'(mon_e.addr));
                end
            end else if (mem_we !== 1'b0) begin
                unexpected("mem_we_without_en");
            end
            chk("fifo_level", 32'(fifo_level), pend_q.size());
            chk("wr_ready", 32'(wr_ready), 32'(pend_q.size() != DEPTH));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("addr_err", 32'(addr_err), 32'(m_aerr));
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
            chk("drop_cnt", 32'(drop_cnt), (m_drops > 65535) ? 32'hFFFF : m_drops);
`else
            chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        end
    end

    initial begin
        logic          r_rst;
        logic          r_rd;
        logic          r_wr;
        logic [AW-1:0] r_ra;
        logic [AW-1:0] r_wa;
        logic [DW-1:0] r_wd;

        // Reset, then idle.
        repeat (3) step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(20);

        // Single read with known RAM contents.
        step(1'b0, 1'b1, 17'h00010, 1'b0, '0, '0);
        idle(6);

        // Three writes drained with no reads.
        step(1'b0, 1'b0, '0, 1'b1, 17'd5, 12'h111);
        step(1'b0, 1'b0, '0, 1'b1, 17'd6, 12'h222);
        step(1'b0, 1'b0, '0, 1'b1, 17'd7, 12'h333);
        idle(6);

        // Overflow while reads hold the port.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 17'(100 + i), 1'b1, 17'(40000 + i), 12'(12'h400 + i));
        end
        step(1'b0, 1'b1, 17'd200, 1'b0, '0, '0);
        idle(8);

        // Out-of-range read and write, including the first invalid address.
        step(1'b0, 1'b1, 17'd76800, 1'b0, '0, '0);
        idle(4);
        step(1'b0, 1'b0, '0, 1'b1, 17'd76800, 12'h555);
        step(1'b0, 1'b1, 17'd76799, 1'b1, 17'd76799, 12'h666);
        idle(6);

        // Reset with reads in flight and writes buffered.
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 17'(300 + i), 1'b1, 17'(41000 + i), 12'(12'h700 + i));
        end
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            r_rd  = ($urandom_range(0, 9) < 6);
            r_ra  = ($urandom_range(0, 15) == 0) ? 17'($urandom_range(PIX, (1 << AW) - 1))
                                                 : 17'($urandom_range(8, 1023));
            r_wr  = ($urandom_range(0, 1) == 1);
            r_wa  = ($urandom_range(0, 15) == 0) ? 17'($urandom_range(PIX, (1 << AW) - 1))
                                                 : 17'(40000 + $urandom_range(0, 999));
            r_wd  = 12'($urandom_range(0, 4095));
            step(r_rst, r_rd, r_ra, r_wr, r_wa, r_wd);
        end
        idle(12);

        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("mem_read_queue_drained", exp_mr.size(), 0);
        chk("mem_write_queue_drained", exp_mw.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
